// File: rtl/hash_pkg.sv
// Shared constants for the cache-index hash pipeline: mode encodings and
// parameter legality limits checked at elaboration by hash_pipe.
package hash_pkg;

    localparam logic [1:0] HASH_MODE_FOLD   = 2'd0;
    localparam logic [1:0] HASH_MODE_SALT   = 2'd1;
    localparam logic [1:0] HASH_MODE_DIRECT = 2'd2;

    localparam int OUTPUT_BITS_MIN = 1;
    localparam int OUTPUT_BITS_MAX = 16;
    localparam int STAGES_MIN      = 1;
    localparam int STAGES_MAX      = 4;

    // Seed must split into two equal halves, each at least one index wide.
    function automatic bit in_bits_legal(input int in_bits, input int out_bits);
        return ((in_bits % 2) == 0) && (in_bits >= 2 * out_bits);
    endfunction

endpackage

// File: rtl/hash_pipe_if.sv
// Request/config/result bundle between the cache controller and hash_pipe.
// master = requester/consumer side, slave = hash_pipe side.
interface hash_pipe_if #(
    parameter int IN_BITS     = 32,
    parameter int OUTPUT_BITS = 2,
    parameter int TAG_BITS    = 4
) ();

    logic                   in_valid;
    logic                   in_ready;
    logic [IN_BITS-1:0]     in_seed;
    logic [TAG_BITS-1:0]    in_tag;
    logic                   cfg_we;
    logic [IN_BITS-1:0]     cfg_salt;
    logic [1:0]             cfg_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUTPUT_BITS-1:0] out_hash;
    logic [TAG_BITS-1:0]    out_tag;

    modport master (
        output in_valid, in_seed, in_tag, cfg_we, cfg_salt, cfg_mode, out_ready,
        input  in_ready, out_valid, out_hash, out_tag
    );

    modport slave (
        input  in_valid, in_seed, in_tag, cfg_we, cfg_salt, cfg_mode, out_ready,
        output in_ready, out_valid, out_hash, out_tag
    );

endinterface

// File: rtl/hash_fold_comb.sv
// Purpose: XOR of consecutive OUTPUT_BITS chunks of the folded half, LSB first.
// Latency: combinational.
// Backpressure: none; pure function of its input.
module hash_fold_comb #(
    parameter int HALF_BITS   = 16,
    parameter int OUTPUT_BITS = 2
) (
    input  logic [HALF_BITS-1:0]   half,
    output logic [OUTPUT_BITS-1:0] hash
);

    localparam int NCHUNK   = (HALF_BITS + OUTPUT_BITS - 1) / OUTPUT_BITS;
    localparam int PAD_BITS = NCHUNK * OUTPUT_BITS;

    logic [PAD_BITS-1:0] padded;

    always_comb begin
        // A partial top chunk contributes zeros above the half width.
        padded                 = '0;
        padded[HALF_BITS-1:0]  = half;
        hash                   = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            hash = hash ^ padded[i*OUTPUT_BITS +: OUTPUT_BITS];
        end
    end

endmodule

// File: rtl/hash_pipe.sv
// Purpose: pipelined salted XOR-fold cache set-index hash with tag pass-through.
// Latency: STAGES cycles from acceptance to out_valid, 1 result/cycle.
// Backpressure: per-stage ready, bubbles collapse; full pipe + !out_ready drops in_ready.
module hash_pipe
    import hash_pkg::*;
#(
    parameter int IN_BITS     = 32,
    parameter int OUTPUT_BITS = 2,
    parameter int STAGES      = 2,
    parameter int TAG_BITS    = 4
) (
    input  logic       clk,
    input  logic       rst,
    hash_pipe_if.slave bus,
    output logic       busy
);

    localparam int HALF_BITS = IN_BITS / 2;

    if (!in_bits_legal(IN_BITS, OUTPUT_BITS)) begin : g_chk_in_bits
        $error("hash_pipe: IN_BITS must be even and >= 2*OUTPUT_BITS");
    end
    if (OUTPUT_BITS < OUTPUT_BITS_MIN || OUTPUT_BITS > OUTPUT_BITS_MAX) begin : g_chk_out_bits
        $error("hash_pipe: OUTPUT_BITS out of range");
    end
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_chk_stages
        $error("hash_pipe: STAGES out of range");
    end

    typedef struct packed {
        logic                 dir;
        logic [HALF_BITS-1:0] val;
    } s1_t;

    logic [IN_BITS-1:0]     salt_q;
    logic [1:0]             mode_q;
    logic [IN_BITS-1:0]     salted;
    logic [IN_BITS-1:0]     mix;
    s1_t                    front;
    logic [STAGES-1:0]      vld;
    logic [STAGES-1:0]      ld;
    logic [STAGES-1:0]      up_vld;
    logic [TAG_BITS-1:0]    tag_q [STAGES];
    logic [OUTPUT_BITS-1:0] out_hash_w;

    // Config only affects requests accepted after the write edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            salt_q <= '0;
            mode_q <= HASH_MODE_FOLD;
        end else if (bus.cfg_we) begin
            salt_q <= bus.cfg_salt;
            mode_q <= bus.cfg_mode;
        end
    end

    always_comb begin
        salted = bus.in_seed ^ salt_q;
        case (mode_q)
            HASH_MODE_SALT: mix = salted;
            HASH_MODE_FOLD: mix = bus.in_seed;
            default:        mix = bus.in_seed;
        endcase
        front.dir = (mode_q == HASH_MODE_DIRECT);
        front.val = mix[IN_BITS-1:HALF_BITS] ^ mix[HALF_BITS-1:0];
        if (front.dir) begin
            front.val                    = '0;
            front.val[OUTPUT_BITS-1:0]   = salted[OUTPUT_BITS-1:0];
        end
    end

    // Ready ripples back from the consumer; an empty stage always accepts.
    always_comb begin : p_ready
        logic nxt;
        nxt = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            nxt   = !vld[k] || nxt;
            ld[k] = nxt;
        end
    end

    always_comb begin
        up_vld[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            up_vld[k] = vld[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) vld[k] <= up_vld[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) tag_q[k] <= '0;
        end else begin
            if (ld[0] && bus.in_valid) tag_q[0] <= bus.in_tag;
            for (int k = 1; k < STAGES; k++) begin
                if (ld[k] && vld[k-1]) tag_q[k] <= tag_q[k-1];
            end
        end
    end

    if (STAGES == 1) begin : g_one
        logic [OUTPUT_BITS-1:0] folded;
        logic [OUTPUT_BITS-1:0] hash_q;

        hash_fold_comb #(.HALF_BITS(HALF_BITS), .OUTPUT_BITS(OUTPUT_BITS)) u_fold (
            .half (front.val),
            .hash (folded)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                hash_q <= '0;
            end else if (ld[0] && bus.in_valid) begin
                hash_q <= front.dir ? front.val[OUTPUT_BITS-1:0] : folded;
            end
        end

        assign out_hash_w = hash_q;
    end else begin : g_multi
        s1_t                    s1_q;
        logic [OUTPUT_BITS-1:0] folded;
        logic [OUTPUT_BITS-1:0] hash_q [1:STAGES-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q <= '0;
            end else if (ld[0] && bus.in_valid) begin
                s1_q <= front;
            end
        end

        hash_fold_comb #(.HALF_BITS(HALF_BITS), .OUTPUT_BITS(OUTPUT_BITS)) u_fold (
            .half (s1_q.val),
            .hash (folded)
        );

        // Stage 2 resolves the hash; later stages are plain delay.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 1; k < STAGES; k++) hash_q[k] <= '0;
            end else begin
                if (ld[1] && vld[0]) hash_q[1] <= s1_q.dir ? s1_q.val[OUTPUT_BITS-1:0] : folded;
                for (int k = 2; k < STAGES; k++) begin
                    if (ld[k] && vld[k-1]) hash_q[k] <= hash_q[k-1];
                end
            end
        end

        assign out_hash_w = hash_q[STAGES-1];
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = vld[STAGES-1];
    assign bus.out_hash  = out_hash_w;
    assign bus.out_tag   = tag_q[STAGES-1];
    assign busy          = |vld;

endmodule

// File: tb/tb_hash_pipe.sv
// Scoreboard bench for hash_pipe: STAGES=2 main instance plus STAGES=1/4 latency instances.
module tb_hash_pipe;
    import hash_pkg::*;

    localparam int IB   = 32;
    localparam int OB   = 2;
    localparam int TAGW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hash_pipe_if #(.IN_BITS(IB), .OUTPUT_BITS(OB), .TAG_BITS(TAGW)) m_if ();
    hash_pipe_if #(.IN_BITS(IB), .OUTPUT_BITS(OB), .TAG_BITS(TAGW)) s1_if ();
    hash_pipe_if #(.IN_BITS(IB), .OUTPUT_BITS(OB), .TAG_BITS(TAGW)) s4_if ();

    logic busy, s1_busy, s4_busy;
    logic side_valid;

    hash_pipe #(.IN_BITS(IB), .OUTPUT_BITS(OB), .STAGES(2), .TAG_BITS(TAGW)) u_dut (
        .clk(clk), .rst(rst), .bus(m_if.slave), .busy(busy));
    hash_pipe #(.IN_BITS(IB), .OUTPUT_BITS(OB), .STAGES(1), .TAG_BITS(TAGW)) u_s1 (
        .clk(clk), .rst(rst), .bus(s1_if.slave), .busy(s1_busy));
    hash_pipe #(.IN_BITS(IB), .OUTPUT_BITS(OB), .STAGES(4), .TAG_BITS(TAGW)) u_s4 (
        .clk(clk), .rst(rst), .bus(s4_if.slave), .busy(s4_busy));

    assign s1_if.in_valid  = side_valid;
    assign s1_if.in_seed   = m_if.in_seed;
    assign s1_if.in_tag    = m_if.in_tag;
    assign s1_if.cfg_we    = m_if.cfg_we;
    assign s1_if.cfg_salt  = m_if.cfg_salt;
    assign s1_if.cfg_mode  = m_if.cfg_mode;
    assign s1_if.out_ready = 1'b1;
    assign s4_if.in_valid  = side_valid;
    assign s4_if.in_seed   = m_if.in_seed;
    assign s4_if.in_tag    = m_if.in_tag;
    assign s4_if.cfg_we    = m_if.cfg_we;
    assign s4_if.cfg_salt  = m_if.cfg_salt;
    assign s4_if.cfg_mode  = m_if.cfg_mode;
    assign s4_if.out_ready = 1'b1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: fold the seed into halves, then XOR OUTPUT_BITS-wide digits of the half.
    function automatic logic [OB-1:0] ref_hash(input logic [IB-1:0] seed, input logic [1:0] mode,
                                               input logic [IB-1:0] salt);
        longint unsigned mix, half, r;
        if (mode == HASH_MODE_DIRECT) begin
            r = longint'(seed ^ salt) % (64'd1 << OB);
            return r[OB-1:0];
        end
        mix  = (mode == HASH_MODE_SALT) ? longint'(seed ^ salt) : longint'(seed);
        half = (mix >> (IB / 2)) ^ (mix % (64'd1 << (IB / 2)));
        r    = 0;
        while (half != 0) begin
            r    = r ^ (half % (64'd1 << OB));
            half = half >> OB;
        end
        return r[OB-1:0];
    endfunction

    typedef struct {
        logic [OB-1:0]   h;
        logic [TAGW-1:0] t;
        int              acc;
    } ent_t;

    ent_t            sb[$];
    logic [1:0]      mdl_mode = 2'd0;
    logic [IB-1:0]   mdl_salt = '0;
    int              drv_exp  = -1;
    int              ncyc     = 0;
    int              last_stall = -1;

    // Monitor: checks status and results each cycle, records acceptances and config writes.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            mdl_mode   = 2'd0;
            mdl_salt   = '0;
            last_stall = ncyc;
        end else begin
            chk("busy", busy, sb.size() != 0);
            chk("in_ready", m_if.in_ready, !(sb.size() == 2 && !m_if.out_ready));
            if (sb.size() == 0) begin
                chk("out_valid_idle", m_if.out_valid, 0);
            end else if (m_if.out_valid) begin
                chk("out_hash", m_if.out_hash, sb[0].h);
                chk("out_tag", m_if.out_tag, sb[0].t);
                if (m_if.out_ready) begin
                    if (last_stall < sb[0].acc) chk("latency", ncyc - sb[0].acc, 2);
                    else chk("latency_min", (ncyc - sb[0].acc) >= 2, 1);
                    void'(sb.pop_front());
                end
            end
            if (!m_if.out_ready) last_stall = ncyc;
            if (m_if.in_valid && m_if.in_ready) begin
                ent_t e;
                e.h   = (drv_exp >= 0) ? drv_exp[OB-1:0] : ref_hash(m_if.in_seed, mdl_mode, mdl_salt);
                e.t   = m_if.in_tag;
                e.acc = ncyc;
                sb.push_back(e);
            end
            if (m_if.cfg_we) begin
                mdl_mode = m_if.cfg_mode;
                mdl_salt = m_if.cfg_salt;
            end
        end
        ncyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IB-1:0] seed, input logic [TAGW-1:0] tag, input int exp);
        int n;
        m_if.in_valid = 1'b1;
        m_if.in_seed  = seed;
        m_if.in_tag   = tag;
        drv_exp       = exp;
        n = 0;
        @(negedge clk);
        while (!m_if.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", m_if.in_ready, 1);
        step();
        m_if.in_valid = 1'b0;
        m_if.cfg_we   = 1'b0;
        drv_exp       = -1;
    endtask

    task automatic cfg(input logic [1:0] mode, input logic [IB-1:0] salt);
        m_if.cfg_we   = 1'b1;
        m_if.cfg_mode = mode;
        m_if.cfg_salt = salt;
        step();
        m_if.cfg_we   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        step();
    endtask

    initial begin
        int  lat1, lat4, acc_cnt;
        bit  acc;
        m_if.in_valid  = 1'b0;
        m_if.in_seed   = '0;
        m_if.in_tag    = '0;
        m_if.cfg_we    = 1'b0;
        m_if.cfg_salt  = '0;
        m_if.cfg_mode  = 2'd0;
        m_if.out_ready = 1'b1;
        side_valid     = 1'b0;
        rst            = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", m_if.out_valid, 0);
        chk("rst_out_hash", m_if.out_hash, 0);
        chk("rst_out_tag", m_if.out_tag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", m_if.in_ready, 1);
        step();

        // STAGES=1 and STAGES=4 latency/result
        side_valid   = 1'b1;
        m_if.in_seed = 32'h1234_5678;
        m_if.in_tag  = 4'hA;
        @(negedge clk);
        chk("s1_in_ready", s1_if.in_ready, 1);
        chk("s4_in_ready", s4_if.in_ready, 1);
        step();
        side_valid = 1'b0;
        lat1 = -1;
        lat4 = -1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (s1_if.out_valid && lat1 < 0) begin
                lat1 = k;
                chk("s1_hash", s1_if.out_hash, 2'h2);
                chk("s1_tag", s1_if.out_tag, 4'hA);
            end
            if (s4_if.out_valid && lat4 < 0) begin
                lat4 = k;
                chk("s4_hash", s4_if.out_hash, 2'h2);
                chk("s4_tag", s4_if.out_tag, 4'hA);
            end
        end
        chk("s1_latency", lat1, 1);
        chk("s4_latency", lat4, 4);
        chk("s1_busy_idle", s1_busy, 0);
        chk("s4_busy_idle", s4_busy, 0);
        step();

        // Fold mode, salt mode, direct mode, same-cycle config write
        send(32'h1234_5678, 4'h5, 2);
        send(32'h0000_0000, 4'h6, 0);
        drain();
        cfg(HASH_MODE_SALT, 32'h0000_0003);
        send(32'h1234_5678, 4'h1, 1);
        cfg(HASH_MODE_DIRECT, 32'h0000_0003);
        send(32'h1234_5678, 4'h2, 3);
        m_if.cfg_we   = 1'b1;
        m_if.cfg_mode = HASH_MODE_FOLD;
        m_if.cfg_salt = 32'h0000_0003;
        send(32'h1234_5678, 4'h3, 3);
        send(32'h1234_5678, 4'h4, 2);
        drain();

        // Back-to-back stream, tags 0..7
        for (int i = 0; i < 8; i++) send($urandom, TAGW'(i), -1);
        drain();

        // Stalled consumer: only two fit
        m_if.out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            m_if.in_valid = 1'b1;
            m_if.in_seed  = $urandom;
            m_if.in_tag   = TAGW'(8 + i);
            @(negedge clk);
            if (m_if.in_ready) acc_cnt++;
            step();
        end
        m_if.in_valid = 1'b0;
        chk("bp_accepted", acc_cnt, 2);
        m_if.out_ready = 1'b1;
        drain();

        // Reset with two entries in flight
        cfg(HASH_MODE_SALT, 32'h0000_0003);
        m_if.out_ready = 1'b0;
        send($urandom, 4'hC, -1);
        send($urandom, 4'hD, -1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", m_if.out_valid, 0);
        chk("midrst_busy", busy, 0);
        step();
        m_if.out_ready = 1'b1;
        send(32'h1234_5678, 4'h9, 2);
        drain();

        // Random traffic, backpressure and config churn
        acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (acc || !m_if.in_valid) begin
                m_if.in_valid = ($urandom % 4) != 0;
                m_if.in_seed  = $urandom;
                m_if.in_tag   = TAGW'($urandom);
            end
            m_if.out_ready = ($urandom % 4) != 0;
            m_if.cfg_we    = ($urandom % 16) == 0;
            m_if.cfg_mode  = 2'($urandom);
            m_if.cfg_salt  = $urandom;
            @(negedge clk);
            acc = m_if.in_valid && m_if.in_ready;
            step();
        end
        m_if.in_valid  = 1'b0;
        m_if.cfg_we    = 1'b0;
        m_if.out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hash_pipe.md
Name: hash_pipe

Overview:
- Pipelined, parametrised successor to the combinational XOR-fold cache-index hash.
- Takes an address/seed with valid/ready handshake and returns an OUTPUT_BITS-wide set index after a fixed register latency.
- Adds a programmable salt and hash mode, per-request tag pass-through, and full backpressure.
- Sits between the cache controller request path and the tag/data array index decode.

Parameters:
- IN_BITS, 32, seed width; must be even and >= 2*OUTPUT_BITS.
- OUTPUT_BITS, 2, hash/index width; range 1..16.
- STAGES, 2, pipeline register stages; range 1..4.
- TAG_BITS, 4, opaque request tag carried alongside the seed.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_seed  in  IN_BITS  value to hash.
- in_tag  in  TAG_BITS  request tag.
- cfg_we  in  1  config write strobe.
- cfg_salt  in  IN_BITS  salt value, written when cfg_we=1.
- cfg_mode  in  2  hash mode, written when cfg_we=1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_hash  out  OUTPUT_BITS  hash result.
- out_tag  out  TAG_BITS  tag of the result.
- busy  out  1  any pipeline stage holds a valid entry.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: salt_q=0, mode_q=0, all stage valid bits 0, out_valid=0, out_hash=0, out_tag=0, busy=0. in_ready=1 in the first cycle after reset.
- Modes (mode_q):
  - 0 FOLD: mix = seed.
  - 1 SALT: mix = seed ^ salt_q.
  - 2 DIRECT: result = (seed ^ salt_q)[OUTPUT_BITS-1:0]; the fold is bypassed.
  - 3 reserved: behaves as 0.
- Fold, for modes 0, 1 and 3:
  - half = mix[IN_BITS-1:IN_BITS/2] ^ mix[IN_BITS/2-1:0], width IN_BITS/2.
  - Result = XOR of consecutive OUTPUT_BITS-wide chunks of half, starting at the LSB.
  - A partial top chunk is zero-padded.
  - With IN_BITS=32 and mode 0, results are bit-identical to the existing hash.
- Config capture:
  - Mode and salt are sampled at acceptance, so each in-flight entry uses the config that applied when it entered.
  - cfg_we in the same cycle as an acceptance: that request uses the OLD config; the new config applies from the next cycle.
- Stage split:
  - Stage 1 registers {half or direct result, mode-derived select, tag}.
  - Stage 2 registers the chunk-XOR result.
  - Stages 3..STAGES are pure delay registers.
  - STAGES=1: the whole computation is done before the single register.
- Latency: exactly STAGES cycles from acceptance to out_valid when out_ready stays high. Throughput is 1 per cycle.
- Backpressure (per-stage ready, bubble-collapsing):
  - Stage k may load when its valid is 0, or when stage k+1 loads or the output is consumed.
  - in_ready = stage 1 may load.
  - A full pipe with out_ready=0 holds all data stable and deasserts in_ready.
  - Results emerge in acceptance order; none are lost or duplicated.
- out_hash and out_tag hold stable while out_valid && !out_ready.
- Reset mid-operation clears all valid bits in the same edge, so in-flight requests are dropped. out_valid=0 in the next cycle; salt and mode return to 0.
- Simultaneous accept and drain on a full pipe: allowed, no stall cycle inserted.
- busy = OR of all stage valid bits.

Decomposition:
- Package hash_pkg:
  - mode constants HASH_MODE_FOLD=2'd0, HASH_MODE_SALT=2'd1, HASH_MODE_DIRECT=2'd2.
  - Width-check constants for the parameter legality assertions (IN_BITS even, ranges).
- Sub-module hash_fold_comb: purely combinational, parameterised by IN_BITS/2 and OUTPUT_BITS, performing the chunk-XOR reduction. Instantiated at stage 2, or in stage 1 when STAGES=1.
- Handshake and valid/data registers stay in hash_pipe.

Test Plan:
- Mode 0, seed 0x1234_5678, OUTPUT_BITS=2, STAGES=2, out_ready=1 -> out_hash=2'h2 exactly 2 cycles after acceptance, tag echoed. Seed 0 -> 2'h0.
- cfg_we with mode=1, salt=0x0000_0003, then seed 0x1234_5678 -> out_hash=2'h1. Switch to mode=2 -> out_hash=2'h3. cfg_we in the same cycle as the request -> that request still uses the old mode.
- 8 back-to-back requests with tags 0..7 and out_ready=1 -> out_valid high on 8 consecutive cycles starting at cycle 2, tags in order 0..7.
- out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 accepted, then in_ready=0; out_hash/out_tag stable. After out_ready=1, all results are in order and none are dropped.
- rst asserted with 2 entries in flight -> out_valid=0 and busy=0 the next cycle; mode 1 salt lost, so seed 0x1234_5678 then hashes as mode 0 -> 2'h2.
- STAGES=1 and STAGES=4 builds, seed 0x1234_5678 -> out_hash=2'h2 with latency 1 and 4 respectively.
